// File: rtl/kernel_attention_pkg.sv
// Shared widths and FSM encoding for the attention-kernel sequential divider.
package kernel_attention_pkg;
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 6;
  localparam int QUO_W      = DIVIDEND_W - DIVISOR_W;
  localparam int CNT_W      = $clog2(QUO_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/kernel_attention_div_16ns_6ns_10_seq_if.sv
// Start/done handshake, operand and result bundle of the sequential divider.
interface kernel_attention_div_16ns_6ns_10_seq_if;
  import kernel_attention_pkg::*;

  logic                  ce;
  logic                  start;
  logic [DIVIDEND_W-1:0] din0;
  logic [DIVISOR_W-1:0]  din1;
  logic                  busy;
  logic                  done;
  logic [QUO_W-1:0]      dout_quo;
  logic [DIVISOR_W-1:0]  dout_rem;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output ce, start, din0, din1,
    input  busy, done, dout_quo, dout_rem, div_by_zero, overflow
  );

  modport slave (
    input  ce, start, din0, din1,
    output busy, done, dout_quo, dout_rem, div_by_zero, overflow
  );
endinterface

// File: rtl/kernel_attention_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, try to subtract D.
module kernel_attention_div_step
  import kernel_attention_pkg::*;
(
  input  logic [DIVISOR_W-1:0] r_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] d_i,
  output logic [DIVISOR_W-1:0] r_o,
  output logic                 q_o
);
  logic [DIVISOR_W:0] t;

  always_comb begin
    t   = {r_i, bit_i};
    q_o = (t >= {1'b0, d_i});
    // r_i < d_i on entry, so either branch fits back into DIVISOR_W bits
    r_o = q_o ? DIVISOR_W'(t - {1'b0, d_i}) : t[DIVISOR_W-1:0];
  end
endmodule

// File: rtl/kernel_attention_div_16ns_6ns_10_seq.sv
// Sequential 16/6 unsigned restoring divider: one quotient bit per ce-enabled cycle.
module kernel_attention_div_16ns_6ns_10_seq
  import kernel_attention_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   reset,
  kernel_attention_div_16ns_6ns_10_seq_if.slave  bus
);
  div_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIVISOR_W-1:0] r_q, r_d;
  logic [DIVISOR_W-1:0] dsr_q, dsr_d;
  logic [QUO_W-1:0]     dvd_q, dvd_d;
  logic [QUO_W-1:0]     acc_q, acc_d;
  logic [QUO_W-1:0]     quo_q, quo_d;
  logic [DIVISOR_W-1:0] rem_q, rem_d;
  logic                 dbz_q, dbz_d;
  logic                 ovf_q, ovf_d;

  logic [DIVISOR_W-1:0] step_r;
  logic                 step_q;
  logic                 accept;

  kernel_attention_div_step u_step (
    .r_i   (r_q),
    .bit_i (dvd_q[QUO_W-1]),
    .d_i   (dsr_q),
    .r_o   (step_r),
    .q_o   (step_q)
  );

  assign accept = bus.ce && bus.start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    dsr_d   = dsr_q;
    dvd_d   = dvd_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    case (state_q)
      RUN: begin
        r_d   = step_r;
        acc_d = {acc_q[QUO_W-2:0], step_q};
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(QUO_W - 1)) begin
          state_d = DONE;
          quo_d   = {acc_q[QUO_W-2:0], step_q};
          rem_d   = step_r;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase

    // An accept in DONE overrides the return to IDLE, giving back-to-back ops
    if (accept) begin
      dbz_d = 1'b0;
      ovf_d = 1'b0;
      dvd_d = bus.din0[QUO_W-1:0];
      dsr_d = bus.din1;
      cnt_d = '0;
      acc_d = '0;
      if (bus.din1 == '0) begin
        dbz_d   = 1'b1;
        quo_d   = '1;
        rem_d   = '0;
        state_d = DONE;
      end else if (bus.din0[DIVIDEND_W-1 -: DIVISOR_W] >= bus.din1) begin
        ovf_d   = 1'b1;
        quo_d   = '1;
        rem_d   = '0;
        state_d = DONE;
      end else begin
        r_d     = bus.din0[DIVIDEND_W-1 -: DIVISOR_W];
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      dsr_q   <= '0;
      dvd_q   <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      dsr_q   <= dsr_d;
      dvd_q   <= dvd_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.dout_quo    = quo_q;
  assign bus.dout_rem    = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_kernel_attention_div_16ns_6ns_10_seq.sv
// Self-checking bench: directed vector table, random ops against an arithmetic model, handshake corners.
module tb_kernel_attention_div_16ns_6ns_10_seq;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  kernel_attention_div_16ns_6ns_10_seq_if bus ();

  kernel_attention_div_16ns_6ns_10_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [5:0]  b;
    logic [9:0]  q;
    logic [5:0]  r;
    logic        dbz;
    logic        ovf;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division, saturating on divide-by-zero or a quotient wider than 10 bits
  function automatic void ref_div(input int a, input int b, output int q, output int r,
                                  output bit dbz, output bit ovf);
    dbz = 1'b0;
    ovf = 1'b0;
    if (b == 0) begin
      dbz = 1'b1; q = 1023; r = 0;
    end else if (a / b > 1023) begin
      ovf = 1'b1; q = 1023; r = 0;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Latency is counted in clock edges from the accepting edge inclusive
  task automatic run_op(input logic [15:0] a, input logic [5:0] b, input int eq, input int er,
                        input bit edbz, input bit eovf, input bit pulse_mid, input string tag);
    int cyc;
    int busy_cnt;
    int exp_lat;
    exp_lat = (edbz || eovf) ? 1 : 11;
    bus.ce    = 1'b1;
    bus.din0  = a;
    bus.din1  = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.din0  = 16'($urandom);
    bus.din1  = 6'($urandom);
    cyc       = 1;
    busy_cnt  = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) busy_cnt++;
      bus.start = pulse_mid && (cyc == 5);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " busy_cycles"}, busy_cnt, exp_lat - 1);
    chk({tag, " quo"}, bus.dout_quo, eq);
    chk({tag, " rem"}, bus.dout_rem, er);
    chk({tag, " dbz"}, bus.div_by_zero, edbz);
    chk({tag, " ovf"}, bus.overflow, eovf);
    @(negedge clk);
    chk({tag, " done_single"}, bus.done, 0);
    chk({tag, " quo_hold"}, bus.dout_quo, eq);
  endtask

  initial begin
    int cyc;
    int q, r;
    bit dbz, ovf;
    logic [15:0] a;
    logic [5:0]  b;

    n_tests = 0;
    n_fail  = 0;

    tbl[0] = '{16'd1000,  6'd20, 10'd50,   6'd0,  1'b0, 1'b0};
    tbl[1] = '{16'd64511, 6'd63, 10'd1023, 6'd62, 1'b0, 1'b0};
    tbl[2] = '{16'd65535, 6'd63, 10'd1023, 6'd0,  1'b0, 1'b1};
    tbl[3] = '{16'd500,   6'd0,  10'd1023, 6'd0,  1'b1, 1'b0};
    tbl[4] = '{16'd777,   6'd13, 10'd59,   6'd10, 1'b0, 1'b0};
    tbl[5] = '{16'd999,   6'd7,  10'd142,  6'd5,  1'b0, 1'b0};
    tbl[6] = '{16'd1023,  6'd1,  10'd1023, 6'd0,  1'b0, 1'b0};
    tbl[7] = '{16'd1024,  6'd1,  10'd1023, 6'd0,  1'b0, 1'b1};
    tbl[8] = '{16'd0,     6'd5,  10'd0,    6'd0,  1'b0, 1'b0};

    reset     = 1'b1;
    bus.ce    = 1'b0;
    bus.start = 1'b0;
    bus.din0  = '0;
    bus.din1  = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset quo", bus.dout_quo, 0);
    chk("reset rem", bus.dout_rem, 0);
    chk("reset flags", {bus.div_by_zero, bus.overflow}, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].ovf,
             (i % 2) == 1, $sformatf("vec%0d", i));
      $display("[TB] vec%0d %0d/%0d -> quo=%0d rem=%0d dbz=%0d ovf=%0d", i, tbl[i].a, tbl[i].b,
               bus.dout_quo, bus.dout_rem, bus.div_by_zero, bus.overflow);
    end

    for (int i = 0; i < 40; i++) begin
      b = 6'($urandom_range(0, 63));
      a = 16'($urandom);
      if (b != 0 && $urandom_range(0, 3) != 0) a = 16'(int'(a) % (int'(b) * 1024));
      ref_div(a, b, q, r, dbz, ovf);
      run_op(a, b, q, r, dbz, ovf, $urandom_range(0, 1) == 1, $sformatf("rnd%0d", i));
      $display("[TB] rnd%0d %0d/%0d -> quo=%0d rem=%0d dbz=%0d ovf=%0d", i, a, b,
               bus.dout_quo, bus.dout_rem, bus.div_by_zero, bus.overflow);
    end

    // ce held low for three edges mid-RUN stretches latency by three
    bus.ce = 1'b1; bus.din0 = 16'd777; bus.din1 = 6'd13; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 50) begin
      bus.ce = !(cyc >= 5 && cyc < 8);
      @(negedge clk);
      cyc++;
    end
    bus.ce = 1'b0;
    chk("stall latency", cyc, 14);
    chk("stall quo", bus.dout_quo, 59);
    chk("stall rem", bus.dout_rem, 10);
    repeat (2) begin
      @(negedge clk);
      chk("stall done_hold", bus.done, 1);
    end
    bus.ce = 1'b1;
    @(negedge clk);
    chk("stall done_clear", bus.done, 0);
    $display("[TB] stall 777/13 -> quo=%0d rem=%0d latency=%0d", bus.dout_quo, bus.dout_rem, cyc);

    // Asynchronous reset at RUN step 5 aborts without a done pulse
    bus.din0 = 16'd777; bus.din1 = 6'd13; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    chk("abort quo", bus.dout_quo, 0);
    chk("abort rem", bus.dout_rem, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort no_done", bus.done, 0);
    run_op(16'd777, 6'd13, 59, 10, 1'b0, 1'b0, 1'b0, "restart");
    $display("[TB] restart 777/13 -> quo=%0d rem=%0d", bus.dout_quo, bus.dout_rem);

    // Back-to-back: start held through the DONE cycle with new operands already presented
    bus.din0 = 16'd1000; bus.din1 = 6'd20; bus.start = 1'b1;
    @(negedge clk);
    bus.din0 = 16'd999; bus.din1 = 6'd7;
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b first latency", cyc, 11);
    chk("b2b first quo", bus.dout_quo, 50);
    chk("b2b first rem", bus.dout_rem, 0);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b second spacing", cyc, 11);
    chk("b2b second quo", bus.dout_quo, 142);
    chk("b2b second rem", bus.dout_rem, 5);
    @(negedge clk);
    chk("b2b idle", bus.done | bus.busy, 0);
    $display("[TB] b2b 999/7 -> quo=%0d rem=%0d spacing=%0d", bus.dout_quo, bus.dout_rem, cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
